// File: rtl/sdram_init_chk.sv
// sdram_init_chk: passive monitor of the SDRAM power-up initialization sequence.
// Optional MRS word check is enabled by defining SDRAM_INIT_CHK_MODE_CHECK_EN.
module sdram_init_chk #(
  parameter int unsigned T_POWERUP = 20000,
  parameter int unsigned T_RP      = 2,
  parameter int unsigned T_RFC     = 7,
  parameter int unsigned T_MRD     = 2,
  parameter int unsigned AR_NUM    = 8,
  parameter logic [12:0] MODE_EXP  = 13'h0037
) (
  input  logic        chk_clk,
  input  logic        chk_rst,
  input  logic [3:0]  chk_cmd,
  input  logic [1:0]  chk_bank,
  input  logic [12:0] chk_addr,
  output logic        chk_done,
  output logic        chk_err,
  output logic [2:0]  chk_err_code,
  output logic [3:0]  chk_ar_cnt,
  output logic [12:0] chk_mode
);

  typedef enum logic [3:0] {
    S_PWR, S_WAIT_PRE, S_TRP, S_WAIT_AR, S_TRFC,
    S_WAIT_MRS, S_TMRD, S_DONE, S_ERR
  } state_e;

  typedef enum logic [2:0] {
    C_DESEL, C_NOP, C_PRE, C_AR, C_MRS, C_OTHER
  } cmd_e;

  localparam logic [15:0] PWR_LD = 16'(T_POWERUP - 1);
  localparam logic [15:0] RP_LD  = 16'(T_RP - 1);
  localparam logic [15:0] RFC_LD = 16'(T_RFC - 1);
  localparam logic [15:0] MRD_LD = 16'(T_MRD - 1);
  localparam logic [3:0]  AR_REQ = 4'(AR_NUM);

  state_e      st_q, st_d, eff;
  logic [15:0] cnt_q, cnt_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [2:0]  code_q, code_d;
  logic [3:0]  ar_q, ar_d;
  logic [12:0] mode_q, mode_d;
  cmd_e        cmd;
  logic        active;

  always_comb begin
    cmd = C_OTHER;
    unique case (1'b1)
      chk_cmd[3]:              cmd = C_DESEL;
      (chk_cmd == 4'b0111):    cmd = C_NOP;
      (chk_cmd == 4'b0010):    cmd = C_PRE;
      (chk_cmd == 4'b0001):    cmd = C_AR;
      (chk_cmd == 4'b0000):    cmd = C_MRS;
      default:                 cmd = C_OTHER;
    endcase
    active = (cmd != C_DESEL) && (cmd != C_NOP);
  end

  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    code_d = code_q;
    ar_d   = ar_q;
    mode_d = mode_q;
    // An expired interval behaves as the wait state it leads to.
    eff = st_q;
    if (cnt_q == 16'd0) begin
      case (st_q)
        S_TRP:   eff = S_WAIT_AR;
        S_TRFC:  eff = (ar_q < AR_REQ) ? S_WAIT_AR : S_WAIT_MRS;
        S_TMRD:  eff = S_DONE;
        default: eff = st_q;
      endcase
    end
    st_d = eff;
    case (eff)
      S_PWR: begin
        if (active) begin
          st_d = S_ERR; code_d = 3'd2;
        end else if (cnt_q == 16'd0) begin
          st_d = S_WAIT_PRE;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_WAIT_PRE: begin
        if (cmd == C_PRE && chk_addr[10]) begin
          st_d = S_TRP; cnt_d = RP_LD;
        end else if (cmd == C_PRE) begin
          st_d = S_ERR; code_d = 3'd3;
        end else if (active) begin
          st_d = S_ERR; code_d = 3'd1;
        end
      end
      S_TRP, S_TRFC, S_TMRD: begin
        if (active) begin
          st_d = S_ERR; code_d = 3'd2;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_WAIT_AR: begin
        if (cmd == C_AR) begin
          ar_d  = (ar_q == 4'hF) ? ar_q : ar_q + 4'd1;
          st_d  = S_TRFC;
          cnt_d = RFC_LD;
        end else if (active) begin
          st_d = S_ERR; code_d = 3'd1;
        end
      end
      S_WAIT_MRS: begin
        if (cmd == C_MRS && chk_bank == 2'd0) begin
          mode_d = chk_addr;
          st_d   = S_TMRD;
          cnt_d  = MRD_LD;
`ifdef SDRAM_INIT_CHK_MODE_CHECK_EN
          if (chk_addr != MODE_EXP) begin
            st_d = S_ERR; code_d = 3'd5;
          end
`endif
        end else if (cmd == C_MRS) begin
          st_d = S_ERR; code_d = 3'd4;
        end else if (active) begin
          st_d = S_ERR; code_d = 3'd1;
        end
      end
      default: ;
    endcase
    done_d = done_q | (eff == S_DONE);
    err_d  = err_q | (st_d == S_ERR);
  end

`ifndef SDRAM_INIT_CHK_MODE_CHECK_EN
  logic mode_exp_unused;
  assign mode_exp_unused = ^MODE_EXP;
`endif

  always_ff @(posedge chk_clk) begin
    if (chk_rst) begin
      st_q   <= S_PWR;
      cnt_q  <= PWR_LD;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      code_q <= 3'd0;
      ar_q   <= 4'd0;
      mode_q <= 13'd0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
      err_q  <= err_d;
      code_q <= code_d;
      ar_q   <= ar_d;
      mode_q <= mode_d;
    end
  end

  assign chk_done     = done_q;
  assign chk_err      = err_q;
  assign chk_err_code = code_q;
  assign chk_ar_cnt   = ar_q;
  assign chk_mode     = mode_q;

endmodule

// File: tb/tb_sdram_init_chk.sv
// tb_sdram_init_chk: table-driven init-sequence checks with an expectation queue.
// Two instances share the bus: default timing, and a short power-up variant.
module tb_sdram_init_chk;

  logic        chk_clk = 1'b0;
  logic        chk_rst;
  logic [3:0]  chk_cmd;
  logic [1:0]  chk_bank;
  logic [12:0] chk_addr;

  logic        done_s, err_s, done_f, err_f;
  logic [2:0]  code_s, code_f;
  logic [3:0]  ar_s, ar_f;
  logic [12:0] mode_s, mode_f;

  always #5 chk_clk = ~chk_clk;

  sdram_init_chk u_slow (
    .chk_clk      (chk_clk),
    .chk_rst      (chk_rst),
    .chk_cmd      (chk_cmd),
    .chk_bank     (chk_bank),
    .chk_addr     (chk_addr),
    .chk_done     (done_s),
    .chk_err      (err_s),
    .chk_err_code (code_s),
    .chk_ar_cnt   (ar_s),
    .chk_mode     (mode_s)
  );

  sdram_init_chk #(.T_POWERUP(100)) u_fast (
    .chk_clk      (chk_clk),
    .chk_rst      (chk_rst),
    .chk_cmd      (chk_cmd),
    .chk_bank     (chk_bank),
    .chk_addr     (chk_addr),
    .chk_done     (done_f),
    .chk_err      (err_f),
    .chk_err_code (code_f),
    .chk_ar_cnt   (ar_f),
    .chk_mode     (mode_f)
  );

  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_DES = 4'b1000;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_AR  = 4'b0001;
  localparam logic [3:0] CMD_MRS = 4'b0000;
  localparam logic [3:0] CMD_ACT = 4'b0011;

  typedef struct packed {
    logic        done;
    logic        err;
    logic [2:0]  code;
    logic [3:0]  ar;
    logic [12:0] mode;
  } exp_t;

  typedef struct {
    string       name;
    bit          sel;
    int          pre_cyc;
    logic [12:0] pre_addr;
    int          first_gap;
    int          ar_gap;
    int          n_ar;
    int          short_idx;
    logic [3:0]  last_cmd;
    logic [1:0]  last_bank;
    logic [12:0] last_addr;
    int          last_gap;
    int          post_gap;
    int          fail_at;
    exp_t        fin;
  } row_t;

  exp_t  sb_q[$];
  string nm_q[$];
  int    n_chk = 0;
  int    n_fail = 0;
  row_t  rows[14];

  task automatic cmp(input string nm, input string f, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %0h, expected %0h", nm, f, act, exp);
    end
  endtask

  task automatic check_out(input string nm, input exp_t e, input bit sel);
    exp_t a;
    if (sel) a = '{done_f, err_f, code_f, ar_f, mode_f};
    else     a = '{done_s, err_s, code_s, ar_s, mode_s};
    cmp(nm, "done", int'(a.done), int'(e.done));
    cmp(nm, "err",  int'(a.err),  int'(e.err));
    cmp(nm, "code", int'(a.code), int'(e.code));
    cmp(nm, "ar",   int'(a.ar),   int'(e.ar));
    cmp(nm, "mode", int'(a.mode), int'(e.mode));
  endtask

  task automatic step(input logic [3:0] c, input logic [12:0] a,
                      input logic [1:0] b, input bit chk, input exp_t e,
                      input string nm, input bit sel);
    exp_t x;
    chk_cmd  = c;
    chk_addr = a;
    chk_bank = b;
    if (chk) begin
      sb_q.push_back(e);
      nm_q.push_back(nm);
    end
    @(posedge chk_clk);
    #1;
    if (chk) begin
      x = sb_q.pop_front();
      check_out(nm_q.pop_front(), x, sel);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step((i % 2 == 1) ? CMD_DES : CMD_NOP, 13'($urandom),
           2'($urandom), 1'b0, '0, "", 1'b0);
  endtask

  task automatic do_reset(input string nm, input bit sel);
    chk_rst = 1'b1;
    chk_cmd = CMD_NOP;
    @(posedge chk_clk);
    @(posedge chk_clk);
    #1;
    check_out({nm, ".rst"}, '0, sel);
    chk_rst = 1'b0;
  endtask

  function automatic exp_t exp_at(input row_t r, input int idx);
    exp_t e;
    e = '0;
    if ((r.fail_at >= 0 && idx >= r.fail_at) || idx >= r.n_ar + 2)
      return r.fin;
    e.ar = (idx <= r.n_ar) ? 4'(idx) : 4'(r.n_ar);
    if (idx == r.n_ar + 1 && r.last_cmd == CMD_MRS && r.last_bank == 2'd0)
      e.mode = r.last_addr;
    return e;
  endfunction

  task automatic run_row(input row_t r);
    int g;
    do_reset(r.name, r.sel);
    idle(r.pre_cyc);
    step(CMD_PRE, r.pre_addr, 2'd3, 1'b1, exp_at(r, 0),
         {r.name, ".pre"}, r.sel);
    for (int k = 0; k < r.n_ar; k++) begin
      g = (k == 0) ? r.first_gap :
          ((k == r.short_idx) ? r.ar_gap - 1 : r.ar_gap);
      idle(g - 1);
      step(CMD_AR, 13'($urandom), 2'($urandom), 1'b1, exp_at(r, k + 1),
           $sformatf("%s.ar%0d", r.name, k), r.sel);
    end
    idle(r.last_gap - 1);
    step(r.last_cmd, r.last_addr, r.last_bank, 1'b1,
         exp_at(r, r.n_ar + 1), {r.name, ".last"}, r.sel);
    if (r.post_gap > 0) begin
      idle(r.post_gap - 1);
      step(CMD_AR, 13'h0, 2'd0, 1'b1, exp_at(r, r.n_ar + 2),
           {r.name, ".post"}, r.sel);
    end
    idle(4);
    step(CMD_NOP, 13'h0, 2'd0, 1'b1, exp_at(r, r.n_ar + 3),
         {r.name, ".final"}, r.sel);
  endtask

  initial begin
    chk_rst  = 1'b1;
    chk_cmd  = CMD_NOP;
    chk_bank = 2'd0;
    chk_addr = 13'd0;

    rows[0]  = '{"legal_def", 1'b0, 20000, 13'h0400, 2, 7, 8, -1,
                 CMD_MRS, 2'd0, 13'h0037, 7, 0, -1,
                 '{1'b1, 1'b0, 3'd0, 4'd8, 13'h0037}};
    rows[1]  = '{"pre_early_def", 1'b0, 19999, 13'h0400, 2, 7, 8, -1,
                 CMD_MRS, 2'd0, 13'h0037, 7, 0, 0,
                 '{1'b0, 1'b1, 3'd2, 4'd0, 13'h0000}};
    rows[2]  = '{"legal_fast", 1'b1, 100, 13'h1FFF, 2, 7, 8, -1,
                 CMD_MRS, 2'd0, 13'h0037, 7, 2, -1,
                 '{1'b1, 1'b0, 3'd0, 4'd8, 13'h0037}};
    rows[3]  = '{"pre_early_fast", 1'b1, 99, 13'h0400, 2, 7, 8, -1,
                 CMD_MRS, 2'd0, 13'h0037, 7, 0, 0,
                 '{1'b0, 1'b1, 3'd2, 4'd0, 13'h0000}};
    rows[4]  = '{"ar_short", 1'b1, 100, 13'h0400, 2, 7, 8, 3,
                 CMD_MRS, 2'd0, 13'h0037, 7, 0, 4,
                 '{1'b0, 1'b1, 3'd2, 4'd3, 13'h0000}};
    rows[5]  = '{"pre_not_all", 1'b1, 100, 13'h1BFF, 2, 7, 8, -1,
                 CMD_MRS, 2'd0, 13'h0037, 7, 0, 0,
                 '{1'b0, 1'b1, 3'd3, 4'd0, 13'h0000}};
    rows[6]  = '{"mrs_bank1", 1'b1, 100, 13'h0400, 2, 7, 8, -1,
                 CMD_MRS, 2'd1, 13'h0037, 7, 0, 9,
                 '{1'b0, 1'b1, 3'd4, 4'd8, 13'h0000}};
    rows[7]  = '{"ninth_ar", 1'b1, 100, 13'h0400, 2, 7, 8, -1,
                 CMD_AR, 2'd0, 13'h0000, 7, 0, 9,
                 '{1'b0, 1'b1, 3'd1, 4'd8, 13'h0000}};
`ifdef SDRAM_INIT_CHK_MODE_CHECK_EN
    rows[8]  = '{"mode_mis", 1'b1, 100, 13'h0400, 2, 7, 8, -1,
                 CMD_MRS, 2'd0, 13'h0032, 7, 0, 9,
                 '{1'b0, 1'b1, 3'd5, 4'd8, 13'h0032}};
`else
    rows[8]  = '{"mode_mis", 1'b1, 100, 13'h0400, 2, 7, 8, -1,
                 CMD_MRS, 2'd0, 13'h0032, 7, 0, -1,
                 '{1'b1, 1'b0, 3'd0, 4'd8, 13'h0032}};
`endif
    rows[9]  = '{"mrs_trfc_short", 1'b1, 100, 13'h0400, 2, 7, 8, -1,
                 CMD_MRS, 2'd0, 13'h0037, 6, 0, 9,
                 '{1'b0, 1'b1, 3'd2, 4'd8, 13'h0000}};
    rows[10] = '{"mrs_after7", 1'b1, 100, 13'h0400, 2, 7, 7, -1,
                 CMD_MRS, 2'd0, 13'h0037, 7, 0, 8,
                 '{1'b0, 1'b1, 3'd1, 4'd7, 13'h0000}};
    rows[11] = '{"ar_trp_short", 1'b1, 100, 13'h0400, 1, 7, 8, -1,
                 CMD_MRS, 2'd0, 13'h0037, 7, 0, 1,
                 '{1'b0, 1'b1, 3'd2, 4'd0, 13'h0000}};
    rows[12] = '{"cmd_in_tmrd", 1'b1, 100, 13'h0400, 2, 7, 8, -1,
                 CMD_MRS, 2'd0, 13'h0037, 7, 1, 10,
                 '{1'b0, 1'b1, 3'd2, 4'd8, 13'h0037}};
    rows[13] = '{"act_in_wait_ar", 1'b1, 100, 13'h0400, 2, 7, 3, -1,
                 CMD_ACT, 2'd0, 13'h0000, 7, 0, 4,
                 '{1'b0, 1'b1, 3'd1, 4'd3, 13'h0000}};

    // Partial sequence on the default instance, abandoned by a reset
    // pulse in rows[0], which then replays the full legal sequence.
    do_reset("mid_rst", 1'b0);
    idle(20000);
    step(CMD_PRE, 13'h0400, 2'd0, 1'b1, '0, "mid_rst.pre", 1'b0);
    idle(1);
    step(CMD_AR, 13'h0, 2'd0, 1'b1, '{1'b0, 1'b0, 3'd0, 4'd1, 13'h0},
         "mid_rst.ar0", 1'b0);
    idle(6);
    step(CMD_AR, 13'h0, 2'd0, 1'b1, '{1'b0, 1'b0, 3'd0, 4'd2, 13'h0},
         "mid_rst.ar1", 1'b0);
    idle(6);
    step(CMD_AR, 13'h0, 2'd0, 1'b1, '{1'b0, 1'b0, 3'd0, 4'd3, 13'h0},
         "mid_rst.ar2", 1'b0);

    for (int i = 0; i < 14; i++)
      run_row(rows[i]);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
